// File: rtl/axi5_pkg.sv
// Shared types and default widths for the AXI5 write responder and its address generator.
package axi5_pkg;

    localparam int AXI_ADDR_W    = 64;
    localparam int AXI_DATA_W    = 16;
    localparam int AXI_ID_W      = 8;
    localparam int AXI_MEM_BYTES = 256;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi5_slave_write_responder_if.sv
// AW/W/B channel bundle between a write master and the subordinate write responder.
interface axi5_slave_write_responder_if
    import axi5_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int ID_W   = AXI_ID_W
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_W-1:0]     AWADDR;
    logic [ID_W-1:0]       AWID;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  WLAST;
    logic                  BVALID;
    logic                  BREADY;
    logic [ID_W-1:0]       BID;
    logic [1:0]            BRESP;

    modport slave (
        input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        input  WVALID, WDATA, WSTRB, WLAST, BREADY,
        output AWREADY, WREADY, BVALID, BID, BRESP
    );

    modport master (
        output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        output WVALID, WDATA, WSTRB, WLAST, BREADY,
        input  AWREADY, WREADY, BVALID, BID, BRESP
    );
endinterface

// File: rtl/axi5_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared by read and write responders.
module axi5_burst_addr_gen
    import axi5_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  burst_e            burst,
    output logic [ADDR_W-1:0] next_addr
);
    logic [ADDR_W-1:0] size_bytes;
    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        size_bytes = ADDR_W'(1) << size;
        aligned    = addr & ~(size_bytes - ADDR_W'(1));
        wrap_mask  = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        next_addr  = addr;
        case (burst)
            INCR:    next_addr = aligned + size_bytes;
            // keep the bits above the wrap window, increment only inside it
            WRAP:    next_addr = (addr & ~wrap_mask) | ((aligned + size_bytes) & wrap_mask);
            default: next_addr = addr;
        endcase
    end
endmodule

// File: rtl/axi5_slave_write_responder.sv
// AXI5 subordinate write path: one burst at a time into a byte memory, B response with sticky errors.
// state | meaning
// IDLE  | AWREADY high, waiting for a write address
// DATA  | WREADY high, consuming AWLEN+1 beats
// RESP  | BVALID high, holding BID/BRESP until BREADY
module axi5_slave_write_responder
    import axi5_pkg::*;
#(
    parameter int ADDR_W    = AXI_ADDR_W,
    parameter int DATA_W    = AXI_DATA_W,
    parameter int ID_W      = AXI_ID_W,
    parameter int MEM_BYTES = AXI_MEM_BYTES
) (
    input  logic                         clk,
    input  logic                         ARESET,
    axi5_slave_write_responder_if.slave  bus,
    input  logic [$clog2(MEM_BYTES)-1:0] dbg_addr,
    output logic [7:0]                   dbg_rdata
);
    localparam int LANES     = DATA_W / 8;
    localparam int LANE_LOG2 = $clog2(LANES);
    localparam int MEM_AW    = $clog2(MEM_BYTES);

    state_e            state, state_nxt;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    burst_e            burst_q;
    logic [8:0]        beat_q;
    logic              slverr_q, decerr_q, illegal_q;

    logic              aw_hs, w_hs, last_beat, beat_oob, aw_illegal;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] size_bytes, size_end, bus_base;
    logic [ADDR_W-1:0] lane_addr [LANES];
    logic [MEM_AW-1:0] lane_idx  [LANES];
    logic [LANES-1:0]  wr_en;
    logic [7:0]        mem [MEM_BYTES];

    assign aw_hs     = bus.AWVALID & bus.AWREADY;
    assign w_hs      = bus.WVALID & bus.WREADY;
    assign last_beat = (beat_q == {1'b0, len_q});
    assign beat_oob  = (addr_q >= ADDR_W'(MEM_BYTES));

    always_comb begin
        aw_illegal = 1'b0;
        if (bus.AWSIZE > 3'(LANE_LOG2))
            aw_illegal = 1'b1;
        if (burst_e'(bus.AWBURST) == RSVD)
            aw_illegal = 1'b1;
        if (burst_e'(bus.AWBURST) == WRAP) begin
            if (!wrap_len_ok(bus.AWLEN))
                aw_illegal = 1'b1;
            if ((bus.AWADDR & ((ADDR_W'(1) << bus.AWSIZE) - ADDR_W'(1))) != '0)
                aw_illegal = 1'b1;
        end
    end

    axi5_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // A lane is live only between the beat address and the end of its size-aligned container.
    always_comb begin
        size_bytes = ADDR_W'(1) << size_q;
        size_end   = (addr_q & ~(size_bytes - ADDR_W'(1))) + size_bytes;
        bus_base   = addr_q & ~ADDR_W'(LANES - 1);
        wr_en      = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_addr[i] = bus_base + ADDR_W'(i);
            lane_idx[i]  = lane_addr[i][MEM_AW-1:0];
            wr_en[i]     = w_hs & ~illegal_q & ~beat_oob & bus.WSTRB[i]
                         & (lane_addr[i] >= addr_q) & (lane_addr[i] < size_end);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i])
                mem[lane_idx[i]] <= bus.WDATA[8*i +: 8];
        end
    end

    assign dbg_rdata = mem[dbg_addr];

    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= FIXED;
            beat_q    <= '0;
            slverr_q  <= 1'b0;
            decerr_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else if (aw_hs) begin
            id_q      <= bus.AWID;
            addr_q    <= bus.AWADDR;
            len_q     <= bus.AWLEN;
            size_q    <= bus.AWSIZE;
            burst_q   <= burst_e'(bus.AWBURST);
            beat_q    <= '0;
            slverr_q  <= aw_illegal;
            decerr_q  <= 1'b0;
            illegal_q <= aw_illegal;
        end else if (w_hs) begin
            beat_q <= beat_q + 9'd1;
            addr_q <= next_addr;
            if (bus.WLAST != last_beat)
                slverr_q <= 1'b1;
            if (beat_oob)
                decerr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aw_hs) state_nxt = DATA;
            DATA:    if (w_hs && last_beat) state_nxt = RESP;
            RESP:    if (bus.BREADY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.AWREADY = (state == IDLE);
        bus.WREADY  = (state == DATA);
        bus.BVALID  = (state == RESP);
        bus.BID     = id_q;
        bus.BRESP   = decerr_q ? DECERR : (slverr_q ? SLVERR : OKAY);
    end
endmodule

// File: tb/tb_axi5_slave_write_responder.sv
// Bench for the AXI5 write responder: directed scenarios plus randomized bursts against a byte-level model.
module tb_axi5_slave_write_responder;
    logic       clk = 1'b0;
    logic       ARESET;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_rdata;

    axi5_slave_write_responder_if bus();

    axi5_slave_write_responder dut (
        .clk       (clk),
        .ARESET    (ARESET),
        .bus       (bus),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] beat_data [16];
    logic [1:0]  beat_strb [16];
    logic        beat_last [16];
    logic [7:0]  mm [256];
    bit          kn [256];

    logic [7:0] obs_bid;
    logic [1:0] obs_bresp;
    bit obs_timeout, obs_wready_lat, obs_bvalid_lat, obs_stable, obs_aw_after, obs_bvalid_after;

    task automatic idle_inputs();
        bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWID = '0; bus.AWLEN = '0;
        bus.AWSIZE = '0; bus.AWBURST = '0; bus.WVALID = 1'b0; bus.WDATA = '0;
        bus.WSTRB = '0; bus.WLAST = 1'b0; bus.BREADY = 1'b0;
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        dbg_addr = 8'(a);
        #1;
        d = dbg_rdata;
    endtask

    // Expected memory effect and response, from the burst rules in plain arithmetic.
    task automatic model_burst(input longint unsigned start, input int len, input int size,
                               input int burst, output logic [1:0] exp);
        longint unsigned nb, a, wb, lower, b;
        bit illegal, slv, dec;
        nb = longint'(1) << size;
        illegal = (size > 1) || (burst == 3) ||
                  (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
                  (burst == 2 && (start % nb) != 0);
        slv = illegal;
        dec = 0;
        for (int k = 0; k <= len; k++) begin
            if (burst == 1)
                a = (k == 0) ? start : (start / nb) * nb + longint'(k) * nb;
            else if (burst == 2) begin
                wb    = longint'(len + 1) * nb;
                lower = (start / wb) * wb;
                a     = lower + ((start - lower + longint'(k) * nb) % wb);
            end else
                a = start;
            if (beat_last[k] != (k == len))
                slv = 1;
            if (a >= 256)
                dec = 1;
            else if (!illegal) begin
                for (int i = 0; i < 2; i++) begin
                    b = (a / 2) * 2 + longint'(i);
                    if (beat_strb[k][i] && b >= a && b < (a / nb) * nb + nb) begin
                        mm[int'(b)] = beat_data[k][8*i +: 8];
                        kn[int'(b)] = 1;
                    end
                end
            end
        end
        exp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endtask

    task automatic do_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int max_gap, input int bready_delay);
        int cnt;
        int gap;
        obs_timeout = 0;
        obs_stable  = 1;
        bus.AWVALID = 1'b1; bus.AWID = id; bus.AWADDR = addr;
        bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
        cnt = 0;
        while (!bus.AWREADY && cnt < 100) begin @(posedge clk); #1; cnt++; end
        if (cnt >= 100) obs_timeout = 1;
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        obs_wready_lat = bus.WREADY;
        for (int k = 0; k <= int'(len); k++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            bus.WVALID = 1'b1; bus.WDATA = beat_data[k];
            bus.WSTRB = beat_strb[k]; bus.WLAST = beat_last[k];
            cnt = 0;
            while (!bus.WREADY && cnt < 100) begin @(posedge clk); #1; cnt++; end
            if (cnt >= 100) obs_timeout = 1;
            @(posedge clk); #1;
            bus.WVALID = 1'b0;
        end
        bus.WLAST = 1'b0;
        obs_bvalid_lat = bus.BVALID;
        obs_bid   = bus.BID;
        obs_bresp = bus.BRESP;
        repeat (bready_delay) begin
            if (!bus.BVALID || bus.BID !== obs_bid || bus.BRESP !== obs_bresp || bus.AWREADY)
                obs_stable = 0;
            @(posedge clk); #1;
        end
        bus.BREADY = 1'b1;
        cnt = 0;
        while (!bus.BVALID && cnt < 100) begin @(posedge clk); #1; cnt++; end
        if (cnt >= 100) obs_timeout = 1;
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
        obs_aw_after     = bus.AWREADY;
        obs_bvalid_after = bus.BVALID;
    endtask

    task automatic test_reset();
        idle_inputs();
        dbg_addr = '0;
        ARESET = 1'b1;
        #12;
        n_cmp++; if (bus.AWREADY !== 1'b1) begin n_err++; $display("FAIL reset_awready got %b want 1", bus.AWREADY); end
        n_cmp++; if (bus.WREADY !== 1'b0) begin n_err++; $display("FAIL reset_wready got %b want 0", bus.WREADY); end
        n_cmp++; if (bus.BVALID !== 1'b0) begin n_err++; $display("FAIL reset_bvalid got %b want 0", bus.BVALID); end
        n_cmp++; if (bus.BID !== 8'h00) begin n_err++; $display("FAIL reset_bid got %h want 00", bus.BID); end
        n_cmp++; if (bus.BRESP !== 2'b00) begin n_err++; $display("FAIL reset_bresp got %b want 00", bus.BRESP); end
        @(posedge clk); #1;
        ARESET = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.AWREADY !== 1'b1) begin n_err++; $display("FAIL post_reset_awready got %b want 1", bus.AWREADY); end
    endtask

    task automatic test_incr_basic();
        logic [1:0] exp;
        logic [7:0] d;
        logic [7:0] want [8];
        want = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
        for (int k = 0; k < 4; k++) begin
            beat_data[k] = 16'h1111 * 16'(k + 1); beat_strb[k] = 2'b11; beat_last[k] = (k == 3);
        end
        model_burst(64'h10, 3, 1, 1, exp);
        do_burst(8'h5A, 64'h10, 8'd3, 3'd1, 2'b01, 0, 0);
        n_cmp++; if (obs_timeout) begin n_err++; $display("FAIL incr_timeout got 1 want 0"); end
        n_cmp++; if (obs_bid !== 8'h5A) begin n_err++; $display("FAIL incr_bid got %h want 5a", obs_bid); end
        n_cmp++; if (obs_bresp !== 2'b00 || exp !== 2'b00) begin n_err++; $display("FAIL incr_bresp got %b want 00", obs_bresp); end
        n_cmp++; if (obs_wready_lat !== 1'b1) begin n_err++; $display("FAIL incr_wready_latency got %b want 1", obs_wready_lat); end
        n_cmp++; if (obs_bvalid_lat !== 1'b1) begin n_err++; $display("FAIL incr_bvalid_latency got %b want 1", obs_bvalid_lat); end
        for (int i = 0; i < 8; i++) begin
            rd(16 + i, d);
            n_cmp++; if (d !== want[i]) begin n_err++; $display("FAIL incr_mem[%0h] got %h want %h", 16 + i, d, want[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp;
        logic [7:0] d;
        int         addrs [8];
        logic [7:0] want  [8];
        // 8-byte wrap window 0x08-0x0F: beats land at 0x0C, 0x0E, 0x08, 0x0A
        addrs = '{12, 13, 14, 15, 8, 9, 10, 11};
        want  = '{8'hD1, 8'hC1, 8'hD2, 8'hC2, 8'hD3, 8'hC3, 8'hD4, 8'hC4};
        for (int k = 0; k < 4; k++) begin
            beat_data[k] = {8'(8'hC1 + k), 8'(8'hD1 + k)}; beat_strb[k] = 2'b11; beat_last[k] = (k == 3);
        end
        model_burst(64'h0C, 3, 1, 2, exp);
        do_burst(8'h21, 64'h0C, 8'd3, 3'd1, 2'b10, 0, 0);
        n_cmp++; if (obs_bresp !== 2'b00 || exp !== 2'b00) begin n_err++; $display("FAIL wrap_bresp got %b want 00", obs_bresp); end
        for (int i = 0; i < 8; i++) begin
            rd(addrs[i], d);
            n_cmp++; if (d !== want[i]) begin n_err++; $display("FAIL wrap_mem[%0h] got %h want %h", addrs[i], d, want[i]); end
        end
    endtask

    task automatic test_decerr();
        logic [1:0] exp;
        logic [7:0] d;
        beat_data[0] = 16'hAB12; beat_data[1] = 16'hCD34;
        beat_strb[0] = 2'b11; beat_strb[1] = 2'b11;
        beat_last[0] = 1'b0; beat_last[1] = 1'b1;
        model_burst(64'hFE, 1, 1, 1, exp);
        do_burst(8'h33, 64'hFE, 8'd1, 3'd1, 2'b01, 0, 0);
        n_cmp++; if (obs_bresp !== 2'b11 || exp !== 2'b11) begin n_err++; $display("FAIL decerr_bresp got %b want 11", obs_bresp); end
        rd(254, d);
        n_cmp++; if (d !== 8'h12) begin n_err++; $display("FAIL decerr_mem[fe] got %h want 12", d); end
        rd(255, d);
        n_cmp++; if (d !== 8'hAB) begin n_err++; $display("FAIL decerr_mem[ff] got %h want ab", d); end
    endtask

    task automatic test_wlast_err();
        logic [1:0] exp;
        logic [7:0] d;
        for (int k = 0; k < 3; k++) begin
            beat_data[k] = {8'(8'h71 + k), 8'(8'h61 + k)}; beat_strb[k] = 2'b11; beat_last[k] = (k == 1);
        end
        model_burst(64'h20, 2, 1, 1, exp);
        do_burst(8'h44, 64'h20, 8'd2, 3'd1, 2'b01, 0, 0);
        n_cmp++; if (obs_timeout) begin n_err++; $display("FAIL wlast_timeout got 1 want 0"); end
        n_cmp++; if (obs_bresp !== 2'b10 || exp !== 2'b10) begin n_err++; $display("FAIL wlast_bresp got %b want 10", obs_bresp); end
        for (int i = 0; i < 3; i++) begin
            rd(32 + 2 * i, d);
            n_cmp++; if (d !== 8'(8'h61 + i)) begin n_err++; $display("FAIL wlast_mem[%0h] got %h want %h", 32 + 2 * i, d, 8'(8'h61 + i)); end
        end
    endtask

    task automatic test_bready_stall();
        logic [1:0] exp;
        for (int k = 0; k < 2; k++) begin
            beat_data[k] = 16'h5A00 + 16'(k); beat_strb[k] = 2'b11; beat_last[k] = (k == 1);
        end
        model_burst(64'h30, 1, 1, 1, exp);
        do_burst(8'hE7, 64'h30, 8'd1, 3'd1, 2'b01, 0, 5);
        n_cmp++; if (obs_stable !== 1'b1) begin n_err++; $display("FAIL stall_stable got %b want 1", obs_stable); end
        n_cmp++; if (obs_bid !== 8'hE7) begin n_err++; $display("FAIL stall_bid got %h want e7", obs_bid); end
        n_cmp++; if (obs_aw_after !== 1'b1) begin n_err++; $display("FAIL stall_awready_after got %b want 1", obs_aw_after); end
        n_cmp++; if (obs_bvalid_after !== 1'b0) begin n_err++; $display("FAIL stall_bvalid_after got %b want 0", obs_bvalid_after); end
    endtask

    task automatic test_reset_mid();
        int cnt;
        bit rose;
        logic [7:0] d;
        bus.AWVALID = 1'b1; bus.AWID = 8'h99; bus.AWADDR = 64'h40;
        bus.AWLEN = 8'd3; bus.AWSIZE = 3'd1; bus.AWBURST = 2'b01;
        cnt = 0;
        while (!bus.AWREADY && cnt < 100) begin @(posedge clk); #1; cnt++; end
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b1; bus.WDATA = 16'hBEEF; bus.WSTRB = 2'b11; bus.WLAST = 1'b0;
        @(posedge clk); #1;
        bus.WVALID = 1'b0;
        mm[64] = 8'hEF; kn[64] = 1;
        mm[65] = 8'hBE; kn[65] = 1;
        ARESET = 1'b1;
        #1;
        n_cmp++; if (bus.AWREADY !== 1'b1) begin n_err++; $display("FAIL rstmid_awready got %b want 1", bus.AWREADY); end
        n_cmp++; if (bus.WREADY !== 1'b0) begin n_err++; $display("FAIL rstmid_wready got %b want 0", bus.WREADY); end
        @(posedge clk); #1;
        ARESET = 1'b0;
        rose = 0;
        repeat (10) begin
            if (bus.BVALID) rose = 1;
            @(posedge clk); #1;
        end
        n_cmp++; if (rose) begin n_err++; $display("FAIL rstmid_bvalid got 1 want 0"); end
        rd(64, d);
        n_cmp++; if (d !== 8'hEF) begin n_err++; $display("FAIL rstmid_mem[40] got %h want ef", d); end
        rd(65, d);
        n_cmp++; if (d !== 8'hBE) begin n_err++; $display("FAIL rstmid_mem[41] got %h want be", d); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 2; k++) begin
                beat_data[k] = 16'($urandom); beat_strb[k] = 2'b11; beat_last[k] = (k == 1);
            end
            model_burst(64'h50 + 64'(4 * n), 1, 1, 1, exp);
            do_burst(8'(8'hB0 + n), 64'h50 + 64'(4 * n), 8'd1, 3'd1, 2'b01, 0, 0);
            n_cmp++; if (obs_timeout || obs_bid !== 8'(8'hB0 + n) || obs_bresp !== exp)
                begin n_err++; $display("FAIL b2b_%0d got bid %h resp %b want bid %h resp %b", n, obs_bid, obs_bresp, 8'(8'hB0 + n), exp); end
            n_cmp++; if (obs_aw_after !== 1'b1) begin n_err++; $display("FAIL b2b_awready_%0d got %b want 1", n, obs_aw_after); end
        end
    endtask

    task automatic test_random();
        logic [1:0] exp;
        int btype, burst, size, len, start, dly;
        logic [7:0] id;
        int lens [6];
        lens = '{1, 3, 7, 15, 2, 5};
        for (int n = 0; n < 40; n++) begin
            btype = int'($urandom_range(0, 9));
            burst = (btype < 3) ? 0 : (btype < 7) ? 1 : (btype < 9) ? 2 : 3;
            size  = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            len   = (burst == 2) ? lens[$urandom_range(0, 5)] : int'($urandom_range(0, 15));
            if (size > 1 || burst >= 2)
                start = int'($urandom_range(0, 'hBF));
            else
                start = int'($urandom_range(0, 'h11F));
            if (burst == 2 && $urandom_range(0, 4) != 0)
                start = start & ~((1 << size) - 1);
            for (int k = 0; k <= len; k++) begin
                beat_data[k] = 16'($urandom);
                beat_strb[k] = 2'($urandom);
                beat_last[k] = (k == len) ^ ($urandom_range(0, 19) == 0);
            end
            id  = 8'($urandom);
            dly = int'($urandom_range(0, 3));
            model_burst(longint'(start), len, size, burst, exp);
            do_burst(id, 64'(start), 8'(len), 3'(size), 2'(burst), 2, dly);
            n_cmp++; if (obs_timeout) begin n_err++; $display("FAIL rnd%0d_timeout got 1 want 0", n); end
            n_cmp++; if (obs_bresp !== exp) begin n_err++; $display("FAIL rnd%0d_bresp got %b want %b", n, obs_bresp, exp); end
            n_cmp++; if (obs_bid !== id) begin n_err++; $display("FAIL rnd%0d_bid got %h want %h", n, obs_bid, id); end
            n_cmp++; if (obs_bvalid_lat !== 1'b1) begin n_err++; $display("FAIL rnd%0d_bvalid_latency got %b want 1", n, obs_bvalid_lat); end
            if (dly > 0) begin
                n_cmp++; if (obs_stable !== 1'b1) begin n_err++; $display("FAIL rnd%0d_stable got %b want 1", n, obs_stable); end
            end
        end
    endtask

    task automatic test_mem_sweep();
        logic [7:0] d;
        for (int a = 0; a < 256; a++) begin
            if (kn[a]) begin
                rd(a, d);
                n_cmp++; if (d !== mm[a]) begin n_err++; $display("FAIL sweep_mem[%0h] got %h want %h", a, d, mm[a]); end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) kn[a] = 0;
        test_reset();
        test_incr_basic();
        test_wrap();
        test_decerr();
        test_wlast_err();
        test_bready_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_mem_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
